// File: rtl/srst_seq_pkg.sv
// Shared types and the group priority picker for the synchronous-reset bank sequencer.
// The picker is sized for the widest supported bank; callers zero-extend their mask.
package srst_seq_pkg;

    localparam int MAX_GRP = 16;
    localparam int IDX_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2,
        FIN    = 2'd3
    } seq_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } grp_pick_t;

    // Lowest set bit strictly above cur, or the lowest set bit overall when first=1.
    function automatic grp_pick_t next_grp(
        input logic [MAX_GRP-1:0] mask,
        input logic [IDX_W-1:0]   cur,
        input logic               first
    );
        grp_pick_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int i = MAX_GRP - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                r.valid = 1'b1;
                r.idx   = IDX_W'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/srst_bank_sequencer.sv
// Walks the unmasked register groups in ascending order, holding each group's sync reset
// for HOLD+1 cycles with a one-cycle gap, then hands the enables back to the user.
module srst_bank_sequencer
    import srst_seq_pkg::*;
#(
    parameter int              NGRP    = 4,
    parameter int              HOLD_W  = 4,
    parameter logic [NGRP-1:0] CE_MASK = '0
) (
    input  logic              C,
    input  logic              R,
    input  logic              START,
    input  logic [HOLD_W-1:0] HOLD,
    input  logic [NGRP-1:0]   MASK,
    input  logic [NGRP-1:0]   EN_REQ,
    output logic [NGRP-1:0]   SRST,
    output logic [NGRP-1:0]   E,
    output logic              BUSY,
    output logic              DONE
);

    seq_state_t        state_reg, state_next;
    logic [IDX_W-1:0]  grp_reg, grp_next;
    logic [HOLD_W-1:0] cnt_reg, cnt_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic [NGRP-1:0]   mask_reg, mask_next;
    logic [NGRP-1:0]   srst_reg, srst_next;
    logic [NGRP-1:0]   e_reg, e_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    grp_pick_t         pick;

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_reg <= IDLE;
            grp_reg   <= '0;
            cnt_reg   <= '0;
            hold_reg  <= '0;
            mask_reg  <= '0;
            srst_reg  <= '0;
            e_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            grp_reg   <= grp_next;
            cnt_reg   <= cnt_next;
            hold_reg  <= hold_next;
            mask_reg  <= mask_next;
            srst_reg  <= srst_next;
            e_reg     <= e_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grp_next   = grp_reg;
        cnt_next   = cnt_reg;
        hold_next  = hold_reg;
        mask_next  = mask_reg;
        pick       = '0;
        case (state_reg)
            IDLE: begin
                if (START) begin
                    hold_next = HOLD;
                    mask_next = MASK;
                    pick      = next_grp(MAX_GRP'(MASK), '0, 1'b1);
                    if (pick.valid) begin
                        state_next = ASSERT;
                        grp_next   = pick.idx;
                        cnt_next   = HOLD;
                    end else begin
                        state_next = FIN;
                    end
                end
            end
            ASSERT: begin
                if (cnt_reg == '0) begin
                    state_next = GAP;
                end else begin
                    cnt_next = cnt_reg - HOLD_W'(1);
                end
            end
            GAP: begin
                // Only the latched mask/hold are used, so mid-sequence input changes are ignored.
                pick = next_grp(MAX_GRP'(mask_reg), grp_reg, 1'b0);
                if (pick.valid) begin
                    state_next = ASSERT;
                    grp_next   = pick.idx;
                    cnt_next   = hold_reg;
                end else begin
                    state_next = FIN;
                end
            end
            FIN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so SRST and E move on the same edge as the FSM.
    for (genvar gi = 0; gi < NGRP; gi++) begin : g_grp_out
        assign srst_next[gi] = (state_next == ASSERT) && (grp_next == IDX_W'(gi));
        assign e_next[gi]    = ((state_next == IDLE) || (state_next == FIN)) ? EN_REQ[gi]
                                                                             : (srst_next[gi] & CE_MASK[gi]);
    end

    assign busy_next = (state_next == ASSERT) || (state_next == GAP);
    assign done_next = (state_next == FIN);

    assign SRST = srst_reg;
    assign E    = e_reg;
    assign BUSY = busy_reg;
    assign DONE = done_reg;

endmodule
